// File: rtl/status_flag_pkg.sv
// Shared constants for the status flag driver: register map, CTRL and STATUS
// bit positions, and display FSM state encodings.
package status_flag_pkg;

    // Register offsets, decoded from wbs_adr_i[3:0]
    localparam logic [3:0] REG_STAGE  = 4'h0;
    localparam logic [3:0] REG_CTRL   = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;

    // CTRL write bits
    localparam int ERR_SET = 0;
    localparam int ERR_CLR = 1;
    localparam int CHECK   = 2;
    localparam int OE      = 3;

    // STATUS read bits
    localparam int ST_EMPTY    = 1;
    localparam int ST_FULL     = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_WDT      = 4;

    // Display FSM states
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

endpackage

// File: rtl/status_flag_fifo.sv
// Small synchronous FIFO queuing stage codes ahead of the display FSM.
// Read data is the head entry (visible without a pop). A pop and a push in
// the same cycle while full are both honoured: the pop frees the slot first.
module status_flag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Accept pops only when data exists; accept pushes when a slot is free
    // now or is being freed by a pop in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + LW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - LW'(1);
        end
    end

    // Pointer, occupancy and storage registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: storage is reset too, so every flop in the block has a defined value out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/status_flag_driver.sv
// Wishbone slave that firmware writes to report test progress on GPIOs.
// Stage writes are queued and each displayed stage is held for at least
// HOLD_CYCLES clocks so a coarse external sampler never misses one.
// Optional watchdog: define STATUS_FLAG_WDT_EN to raise error when no STAGE
// write arrives within WDT_CYCLES clocks.
module status_flag_driver
    import status_flag_pkg::*;
#(
    parameter int          HOLD_CYCLES = 256,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          WDT_CYCLES  = 65536
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  stage_o,
    output logic        error_o,
    output logic        check_o,
    output logic [9:0]  io_oeb_o
);

    localparam int                CNT_W     = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam int                LVL_W     = $clog2(FIFO_DEPTH) + 1;

    // Bus side
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        wb_sel;
    logic        wr_commit;
    logic        wr_stage;
    logic        wr_ctrl;
    logic [31:0] rdata;

    // Flags
    logic error_q, error_d;
    logic check_q, check_d;
    logic oe_q, oe_d;
    logic ovf_q, ovf_d;
    logic wdt_fire;
    logic wdt_fired;

    // Display FSM
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       stage_q, stage_d;
    logic             pop;

    // FIFO
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [2:0]       level3;

    logic unused_ok;
    assign unused_ok = ^{wbs_dat_i[31:8], wbs_sel_i[3:1]};

    assign level3 = 3'(fifo_level);

    // Address decode; a write takes effect during its ack cycle
    always_comb begin
        wb_sel    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        wr_commit = ack_q && wb_sel && wbs_we_i && wbs_sel_i[0];
        wr_stage  = wr_commit && (wbs_adr_i[3:0] == REG_STAGE);
        wr_ctrl   = wr_commit && (wbs_adr_i[3:0] == REG_CTRL);
    end

    // Read mux, captured into the data register on the selection cycle
    always_comb begin
        rdata = '0;
        case (wbs_adr_i[3:0])
            REG_STAGE:  rdata = {21'b0, level3, stage_q};
            REG_CTRL:   rdata = {28'b0, oe_q, check_q, 1'b0, error_q};
            REG_STATUS: rdata = {27'b0, wdt_fired, ovf_q, fifo_full, fifo_empty, 1'b0};
            default:    rdata = '0;
        endcase
    end

    // One-cycle ack, never two in a row; read data only alongside ack
    always_comb begin
        ack_d = wb_sel && !ack_q;
        dat_d = (wb_sel && !ack_q && !wbs_we_i) ? rdata : '0;
    end

    // Error, check, output-enable and overflow flag updates
    always_comb begin
        error_d = error_q;
        check_d = check_q;
        oe_d    = oe_q;
        ovf_d   = ovf_q;
        if (wr_ctrl) begin
            if (wbs_dat_i[ERR_CLR]) begin
                error_d = 1'b0;
                ovf_d   = 1'b0;
            end
            if (wbs_dat_i[ERR_SET]) begin
                error_d = 1'b1;
            end
            check_d = wbs_dat_i[CHECK];
            oe_d    = wbs_dat_i[OE];
        end
        if (wr_stage && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (wdt_fire) begin
            error_d = 1'b1;
        end
    end

    // Display FSM: pop a queued stage, show it, hold it for HOLD_CYCLES clocks
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    stage_d = fifo_dout;
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        stage_d = fifo_dout;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STATUS_FLAG_WDT_EN
    localparam int               WDT_W    = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LOAD = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_run_q, wdt_run_d;
    logic             wdt_fired_q, wdt_fired_d;

    // Watchdog: kicked by STAGE writes, fires once and parks at zero
    always_comb begin
        wdt_cnt_d   = wdt_cnt_q;
        wdt_run_d   = wdt_run_q;
        wdt_fired_d = wdt_fired_q;
        wdt_fire    = 1'b0;
        if (wr_stage) begin
            wdt_cnt_d = WDT_LOAD;
            wdt_run_d = 1'b1;
        end else if (wdt_run_q) begin
            if (wdt_cnt_q == '0) begin
                wdt_fire  = 1'b1;
                wdt_run_d = 1'b0;
            end else begin
                wdt_cnt_d = wdt_cnt_q - WDT_W'(1);
            end
        end
        if (wr_ctrl && wbs_dat_i[ERR_CLR]) begin
            wdt_fired_d = 1'b0;
        end
        if (wdt_fire) begin
            wdt_fired_d = 1'b1;
        end
    end

    // Watchdog registers; counting starts straight out of reset
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q   <= WDT_LOAD;
            wdt_run_q   <= 1'b1;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_run_q   <= wdt_run_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign wdt_fired = wdt_fired_q;
`else
    logic unused_wdt;
    assign unused_wdt = (WDT_CYCLES > 0);
    assign wdt_fire   = 1'b0;
    assign wdt_fired  = 1'b0;
`endif

    // Bus, flag and display registers
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            error_q <= 1'b0;
            check_q <= 1'b0;
            oe_q    <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            error_q <= error_d;
            check_q <= check_d;
            oe_q    <= oe_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    status_flag_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_n   (rst_n),
        .push_i  (wr_stage),
        .data_i  (wbs_dat_i[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign stage_o   = stage_q;
    assign error_o   = error_q;
    assign check_o   = check_q;
    assign io_oeb_o  = oe_q ? 10'h000 : 10'h3FF;

endmodule
